// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and sizing helpers for the fetch queue
package fetch_queue_pkg;

    // Default data/address width of the fetch path.
    localparam int XLEN = 32;

    // Value shown on the instruction output while the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch stride in bytes.
    localparam int PC_INC = 4;

    // Width of a counter that must hold 0..d inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

    // Width of a pointer into a d-entry array; never zero wide.
    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - synchronous first-word-fallthrough FIFO
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   push       write push_data at the tail (ignored when full without pop)
//   push_data  tail write data
//   pop        drop the head entry (ignored when empty)
//   clear      empty the FIFO; dominates push and pop
//   head       current head entry, valid whenever count != 0
//   count      occupied entries, 0..DEPTH
module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    input  logic                      clear,
    output logic [WIDTH-1:0]          head,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two (the tag FIFO is MAXOUT deep),
    // so wrap explicitly instead of relying on pointer overflow.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch with outstanding requests, instruction queue and redirect flush
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   redirect     restart fetch at redirect_pc (flushes queued and in-flight work)
//   redirect_pc  new fetch address, low two bits ignored
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_gnt     request accepted this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response instruction word
//   instr_valid  queue head valid
//   instr        queue head instruction (NOP when empty)
//   pcplus4      queue head PC+4 (0 when empty)
//   instr_ready  decode accepts the head
//   count        occupied queue entries
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter int               MAXOUT   = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     imem_req,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [WIDTH-1:0]         imem_rdata,
    output logic                     instr_valid,
    output logic [WIDTH-1:0]         instr,
    output logic [WIDTH-1:0]         pcplus4,
    input  logic                     instr_ready,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int OW = cnt_w(MAXOUT);
    localparam int SW = CW + 1;

    logic [WIDTH-1:0]   pc_f;
    logic [OW-1:0]      outstanding;
    logic [OW-1:0]      discard;
    logic [CW-1:0]      q_count;
    logic [2*WIDTH-1:0] q_head;
    logic [WIDTH-1:0]   tag_head;
    logic [SW-1:0]      in_use;
    logic               issue;
    logic               rsp;
    logic               keep;
    logic               q_pop;

    // Queue slots already spoken for: filled entries plus every response
    // still owed. Issuing only while this is below DEPTH means a response
    // always has room, so the memory never sees back-pressure.
    assign in_use = {1'b0, q_count} + SW'(outstanding);

    always_comb begin
        imem_req = rst && !redirect
                   && (outstanding < OW'(MAXOUT))
                   && (in_use < SW'(DEPTH));
        issue    = imem_req && imem_gnt;
        // A response with nothing outstanding is a protocol error; ignore it.
        rsp      = imem_rvalid && (outstanding != '0);
        // Stale responses (discard > 0) and responses landing on a redirect
        // edge are consumed from the tag FIFO but never enter the queue.
        keep     = rsp && (discard == '0) && !redirect;
        q_pop    = instr_valid && instr_ready && !redirect;
    end

    // Instruction queue: {instruction, pc+4} per entry.
    sync_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (keep),
        .push_data ({imem_rdata, tag_head + WIDTH'(PC_INC)}),
        .pop       (q_pop),
        .clear     (redirect),
        .head      (q_head),
        .count     (q_count)
    );

    // Tag FIFO: address of every in-flight request, in issue order. It is
    // never flushed on redirect because stale responses still return and
    // must retire their tags; its occupancy is the outstanding count.
    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (MAXOUT)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (pc_f),
        .pop       (rsp),
        .clear     (1'b0),
        .head      (tag_head),
        .count     (outstanding)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f    <= RESET_PC;
            discard <= '0;
        end else begin
            if (redirect) begin
                pc_f <= {redirect_pc[WIDTH-1:2], 2'b00};
            end else if (issue) begin
                pc_f <= pc_f + WIDTH'(PC_INC);
            end

            // Everything still in flight after this edge belongs to the
            // old path; the in-order return means it is the next N words.
            if (redirect) begin
                discard <= outstanding - OW'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    assign imem_addr   = pc_f;
    assign instr_valid = (q_count != '0);
    assign instr       = instr_valid ? q_head[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
    assign pcplus4     = instr_valid ? q_head[WIDTH-1:0] : '0;
    assign count       = q_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-level model
module tb_fetch_queue;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int MAXOUT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect = 1'b0;
    logic [WIDTH-1:0]  redirect_pc = '0;
    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_gnt = 1'b1;
    logic              imem_rvalid = 1'b0;
    logic [WIDTH-1:0]  imem_rdata = '0;
    logic              instr_valid;
    logic [WIDTH-1:0]  instr;
    logic [WIDTH-1:0]  pcplus4;
    logic              instr_ready = 1'b1;
    logic [2:0]        count;

    fetch_queue #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAXOUT   (MAXOUT),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pcplus4     (pcplus4),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pops  = 0;

    // Memory environment: issued requests with the cycle they may return.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;
    mem_t mem_q[$];

    // Behavioural model: fetch PC, addresses in flight, words to discard,
    // and the instruction queue as {instr, pc+4}.
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    int          m_disc;
    logic [63:0] m_iq[$];

    // Stimulus knobs.
    int          lat      = 1;
    bit          gnt_rand = 0;
    bit          rv_rand  = 0;
    bit          force_rv = 0;
    bit          rdy      = 1;
    bit          redir    = 0;
    logic [31:0] rpc      = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_infl.delete();
        m_iq.delete();
        m_disc = 0;
        mem_q.delete();
    endtask

    task automatic step();
        bit          from_mem;
        bit          exp_req;
        bit          issue;
        bit          keep;
        logic [31:0] tag;
        logic [63:0] h;
        @(negedge clk);
        cyc++;
        imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        from_mem = 0;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc
                     && (!rv_rand || $urandom_range(0, 1) == 1)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ 32'hA5A5_0000;
            from_mem    = 1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;

        exp_req = !redir && (m_infl.size() < MAXOUT)
                  && ((m_iq.size() + m_infl.size()) < DEPTH);
        h = (m_iq.size() > 0) ? m_iq[0] : 64'h0;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_iq.size() > 0));
        chk("instr", instr, h[63:32]);
        chk("pcplus4", pcplus4, h[31:0]);
        chk("count", 32'(count), 32'(m_iq.size()));
        if (instr_valid && instr_ready) pops++;

        if (from_mem) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) mem_q.push_back('{imem_addr, cyc + lat});

        issue = exp_req && imem_gnt;
        keep  = 0;
        tag   = '0;
        if (imem_rvalid && m_infl.size() > 0) begin
            tag = m_infl.pop_front();
            if (m_disc > 0) m_disc--;
            else if (!redir) keep = 1;
        end
        if (!redir && rdy && m_iq.size() > 0) void'(m_iq.pop_front());
        if (keep) m_iq.push_back({imem_rdata, tag + 32'd4});
        if (redir) begin
            m_iq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_disc = m_infl.size();
        end else if (issue) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        #1;
        chk("rst imem_req", 32'(imem_req), 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst instr_valid", 32'(instr_valid), 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst pcplus4", pcplus4, 32'h0);
        chk("rst count", 32'(count), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        do_reset();

        // Zero-latency stream from reset.
        step(); chk("s0 addr", imem_addr, 32'h0); chk("s0 req", 32'(imem_req), 32'h1);
        step(); chk("s1 addr", imem_addr, 32'h4); chk("s1 valid", 32'(instr_valid), 32'h0);
        step(); chk("s2 valid", 32'(instr_valid), 32'h1);
                chk("s2 pcplus4", pcplus4, 32'h4);
                chk("s2 instr", instr, 32'hA5A5_0000);
        step(); chk("s3 pcplus4", pcplus4, 32'h8);
        step(); chk("s4 pcplus4", pcplus4, 32'hC);
        step();

        // Decode stall: queue fills, credit blocks further issue.
        rdy = 0;
        repeat (10) step();
        chk("stall count", 32'(count), 32'h4);
        chk("stall req", 32'(imem_req), 32'h0);
        rdy = 1;
        repeat (8) step();

        // Longer latency: throughput bounded by MAXOUT.
        lat = 2;
        repeat (6) step();
        pops = 0;
        repeat (30) step();
        chk("lat2 throughput ok", 32'(pops >= 18), 32'h1);

        // Redirect with work in flight and queued.
        lat = 3; rdy = 0; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (m_infl.size() == 2 && m_iq.size() >= 1) found = 1;
        end
        chk("redir setup reached", 32'(found), 32'h1);
        redir = 1; rpc = 32'h0000_0103; step(); redir = 0;
        step();
        chk("redir count", 32'(count), 32'h0);
        chk("redir addr", imem_addr, 32'h0000_0100);
        rdy = 1; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (instr_valid) found = 1;
        end
        chk("redir first valid", 32'(found), 32'h1);
        chk("redir first pcplus4", pcplus4, 32'h0000_0104);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        repeat (6) step();
        redir = 1; rpc = 32'h0000_2002; step(); redir = 0;
        chk("coinc head valid", 32'(instr_valid), 32'h1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (instr_valid) found = 1;
        end
        chk("coinc first valid", 32'(found), 32'h1);
        chk("coinc first pcplus4", pcplus4, 32'h0000_2004);

        // Reset with a request outstanding, then a spurious response.
        lat = 3; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (m_infl.size() == 1) found = 1;
        end
        chk("mid reset setup", 32'(found), 32'h1);
        do_reset();
        lat = 1;
        force_rv = 1; step(); force_rv = 0;
        step();
        chk("spurious count", 32'(count), 32'h0);
        repeat (4) step();

        // Randomized traffic.
        for (int blk = 0; blk < 20; blk++) begin
            lat      = $urandom_range(1, 4);
            gnt_rand = $urandom_range(0, 1);
            rv_rand  = $urandom_range(0, 1);
            for (int i = 0; i < 100; i++) begin
                rdy   = ($urandom_range(0, 3) != 0);
                redir = ($urandom_range(0, 23) == 0);
                rpc   = $urandom;
                step();
            end
        end
        redir = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
